// File: rtl/car_sensor.sv
// car_sensor
// Country-road vehicle detector for the traffic signal controller.
// Synchronises and debounces the raw inductive-loop input, counts confirmed
// arrivals, and retires queued cars while the country light is GREEN.
//
// Ports:
//   clock      in  1      single clock, rising edge
//   clear      in  1      asynchronous active-high reset
//   loop_raw   in  1      raw loop sensor (asynchronous), 1 = vehicle present
//   cntry      in  2      country light code: RED=0, YELLOW=1, GREEN=2, 3=not GREEN
//   X          out 1      car-waiting request, high while any car is queued
//   car_count  out CNT_W  number of queued cars
//   overflow   out 1      sticky: an arrival was lost at saturation
module car_sensor #(
  parameter int DEBOUNCE    = 4,
  parameter int PASS_CYCLES = 3,
  parameter int CNT_W       = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             loop_raw,
  input  logic [1:0]       cntry,
  output logic             X,
  output logic [CNT_W-1:0] car_count,
  output logic             overflow
);

  localparam int DB_W = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam int PC_W = (PASS_CYCLES > 1) ? $clog2(PASS_CYCLES) : 1;

  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [DB_W-1:0]  DB_ONE  = DB_W'(1);
  localparam logic [PC_W-1:0]  PC_LAST = PC_W'(PASS_CYCLES - 1);
  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [1:0]       GREEN   = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY       = 2'd0,
    S_CONFIRM_ON  = 2'd1,
    S_OCCUPIED    = 2'd2,
    S_CONFIRM_OFF = 2'd3
  } state_t;

  logic             r_s1;
  logic             r_loop_s;
  state_t           r_state;
  state_t           w_state_next;
  logic [DB_W-1:0]  r_db_cnt;
  logic [DB_W-1:0]  w_db_cnt_next;
  logic [PC_W-1:0]  r_pass_cnt;
  logic [CNT_W-1:0] r_car_count;
  logic             r_overflow;
  logic             w_arrive;
  logic             w_green;
  logic             w_pass_wrap;
  logic             w_depart;

  // Two-flop synchroniser for the asynchronous loop input.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_s1     <= 1'b0;
      r_loop_s <= 1'b0;
    end else begin
      r_s1     <= loop_raw;
      r_loop_s <= r_s1;
    end
  end

  // Debounce FSM: state register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state  <= S_EMPTY;
      r_db_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_db_cnt <= w_db_cnt_next;
    end
  end

  // Debounce FSM: next-state logic. A level must be seen for DEBOUNCE
  // consecutive cycles (entry cycle counts as 1) before it is accepted.
  always_comb begin
    w_state_next  = r_state;
    w_db_cnt_next = r_db_cnt;
    case (r_state)
      S_EMPTY: begin
        if (r_loop_s) begin
          w_state_next  = S_CONFIRM_ON;
          w_db_cnt_next = DB_ONE;
        end
      end
      S_CONFIRM_ON: begin
        if (!r_loop_s) begin
          w_state_next  = S_EMPTY;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_next  = S_OCCUPIED;
        end else begin
          w_db_cnt_next = r_db_cnt + DB_ONE;
        end
      end
      S_OCCUPIED: begin
        if (!r_loop_s) begin
          w_state_next  = S_CONFIRM_OFF;
          w_db_cnt_next = DB_ONE;
        end
      end
      S_CONFIRM_OFF: begin
        // A short dropout returns to OCCUPIED without a new arrival.
        if (r_loop_s) begin
          w_state_next  = S_OCCUPIED;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_next  = S_EMPTY;
        end else begin
          w_db_cnt_next = r_db_cnt + DB_ONE;
        end
      end
      default: begin
        w_state_next  = S_EMPTY;
        w_db_cnt_next = '0;
      end
    endcase
  end

  // Debounce FSM: output logic. The arrival pulse coincides with the
  // CONFIRM_ON -> OCCUPIED edge so the counter updates on that same edge.
  always_comb begin
    w_arrive = 1'b0;
    if (r_state == S_CONFIRM_ON && r_loop_s && r_db_cnt == DB_LAST) begin
      w_arrive = 1'b1;
    end
  end

  // Pass timer: one departure per PASS_CYCLES edges of continuous GREEN.
  assign w_green     = (cntry == GREEN);
  assign w_pass_wrap = w_green && (r_pass_cnt == PC_LAST);
  assign w_depart    = w_pass_wrap && (r_car_count != '0);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_pass_cnt <= '0;
    end else if (!w_green || w_pass_wrap) begin
      r_pass_cnt <= '0;
    end else begin
      r_pass_cnt <= r_pass_cnt + PC_ONE;
    end
  end

  // Queue counter. Simultaneous arrive and depart cancel, so no overflow
  // is flagged in that case even at saturation.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_car_count <= '0;
      r_overflow  <= 1'b0;
    end else if (w_arrive && !w_depart) begin
      if (r_car_count == CNT_MAX) begin
        r_overflow  <= 1'b1;
      end else begin
        r_car_count <= r_car_count + CNT_ONE;
      end
    end else if (w_depart && !w_arrive) begin
      r_car_count <= r_car_count - CNT_ONE;
    end
  end

  assign car_count = r_car_count;
  assign overflow  = r_overflow;
  assign X         = (r_car_count != '0);

endmodule

// File: tb/tb_car_sensor.sv
// Scoreboard bench for car_sensor (DEBOUNCE=4, PASS_CYCLES=3, CNT_W=2).
// Stimulus pushes the expected {car_count, X, overflow} value and the edge
// number on which it must appear; the monitor pops an entry every time the
// DUT outputs change and compares both the value and the edge number.
module tb_car_sensor;

  logic       clock;
  logic       clear;
  logic       loop_raw;
  logic [1:0] cntry;
  logic       X;
  logic [1:0] car_count;
  logic       overflow;

  car_sensor #(
    .DEBOUNCE    (4),
    .PASS_CYCLES (3),
    .CNT_W       (2)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .loop_raw  (loop_raw),
    .cntry     (cntry),
    .X         (X),
    .car_count (car_count),
    .overflow  (overflow)
  );

  typedef struct {
    logic [3:0] val;   // {car_count, X, overflow}
    int         cyc;
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end else begin
      $display("check %s value=%0d ok", nm, act);
    end
  endtask

  task automatic push(input logic [1:0] cnt, input logic ov, input int at, input string nm);
    exp_t e;
    e.val  = {cnt, (cnt != 2'd0), ov};
    e.cyc  = at;
    e.name = nm;
    q.push_back(e);
  endtask

  // One car on the loop for hi cycles, then clear of it for lo cycles.
  // The count changes 6 edges after the negedge on which loop_raw rises.
  task automatic car(input int hi, input int lo, input bit expect_change,
                     input logic [1:0] cnt, input logic ov, input string nm);
    if (expect_change) push(cnt, ov, cyc + 6, nm);
    loop_raw = 1'b1;
    repeat (hi) @(negedge clock);
    loop_raw = 1'b0;
    repeat (lo) @(negedge clock);
  endtask

  // Monitor: any change on the outputs consumes one scoreboard entry.
  initial begin
    logic [3:0] prev;
    logic [3:0] cur;
    exp_t       e;
    wait (mon_en);
    prev = {car_count, X, overflow};
    forever begin
      @(negedge clock);
      cur = {car_count, X, overflow};
      if (cur !== prev) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_change actual=%0h required=%0h at_edge=%0d", cur, prev, cyc);
        end else begin
          e = q.pop_front();
          chk(e.name, int'(cur), int'(e.val));
          chk({e.name, "_edge"}, cyc, e.cyc);
        end
      end
      prev = cur;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    clear    = 1'b1;
    loop_raw = 1'b0;
    cntry    = 2'd0;
    repeat (3) @(negedge clock);
    clear  = 1'b0;
    mon_en = 1'b1;
    chk("reset_state", int'({car_count, X, overflow}), 0);

    // Glitch rejection: ten 3-cycle pulses never confirm.
    for (int i = 0; i < 10; i++) begin
      loop_raw = 1'b1;
      repeat (3) @(negedge clock);
      loop_raw = 1'b0;
      repeat (4) @(negedge clock);
    end
    chk("glitch_count", int'(car_count), 0);
    chk("glitch_x", int'(X), 0);

    // Single car held 20 cycles: exactly one arrival.
    car(20, 10, 1'b1, 2'd1, 1'b0, "single_car");

    // Occupied period with a 2-cycle dropout: one arrival only.
    c = cyc;
    push(2'd2, 1'b0, c + 6, "dropout_car");
    loop_raw = 1'b1;
    repeat (10) @(negedge clock);
    loop_raw = 1'b0;
    repeat (2) @(negedge clock);
    loop_raw = 1'b1;
    repeat (10) @(negedge clock);
    loop_raw = 1'b0;
    repeat (10) @(negedge clock);

    // Departures: count 2, GREEN held 9 edges -> decrements at edges 3 and 6.
    c = cyc;
    push(2'd1, 1'b0, c + 3, "depart_1");
    push(2'd0, 1'b0, c + 6, "depart_2");
    cntry = 2'd2;
    repeat (9) @(negedge clock);
    cntry = 2'd0;
    repeat (4) @(negedge clock);
    chk("no_underflow", int'(car_count), 0);

    // Simultaneous arrive/depart at count 1: hold, then drain at next pass.
    car(8, 8, 1'b1, 2'd1, 1'b0, "simul_prep");
    c = cyc;
    push(2'd0, 1'b0, c + 9, "simul_drain");
    loop_raw = 1'b1;
    repeat (3) @(negedge clock);
    cntry = 2'd2;                    // first GREEN edge c+4, depart at c+6
    repeat (4) @(negedge clock);
    chk("simul_hold", int'({car_count, X}), 3'b011);
    repeat (2) @(negedge clock);
    cntry = 2'd0;
    loop_raw = 1'b0;
    repeat (10) @(negedge clock);

    // Saturation with CNT_W=2: fourth car sets overflow, fifth is silent.
    car(8, 8, 1'b1, 2'd1, 1'b0, "sat_car1");
    car(8, 8, 1'b1, 2'd2, 1'b0, "sat_car2");
    car(8, 8, 1'b1, 2'd3, 1'b0, "sat_car3");
    car(8, 8, 1'b1, 2'd3, 1'b1, "sat_car4_ovf");
    car(8, 8, 1'b0, 2'd3, 1'b1, "sat_car5");
    c = cyc;
    push(2'd2, 1'b1, c + 3, "sat_drain1");
    push(2'd1, 1'b1, c + 6, "sat_drain2");
    push(2'd0, 1'b1, c + 9, "sat_drain3");
    cntry = 2'd2;
    repeat (12) @(negedge clock);
    cntry = 2'd0;
    repeat (2) @(negedge clock);
    chk("ovf_sticky", int'(overflow), 1);

    // Async clear mid-CONFIRM_ON with count 2.
    car(8, 8, 1'b1, 2'd1, 1'b1, "pre_rst1");
    car(8, 8, 1'b1, 2'd2, 1'b1, "pre_rst2");
    loop_raw = 1'b1;
    repeat (4) @(negedge clock);
    @(posedge clock);
    #2;
    push(2'd0, 1'b0, cyc, "async_clear_mon");
    clear = 1'b1;
    #1;
    chk("async_clear", int'({car_count, X, overflow}), 0);
    repeat (2) @(negedge clock);
    c = cyc;
    push(2'd1, 1'b0, c + 6, "rearrive");
    clear = 1'b0;
    repeat (10) @(negedge clock);
    loop_raw = 1'b0;
    repeat (20) @(negedge clock);

    chk("sb_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
